// File: rtl/sensor_ascii_framer.sv
// Captures one binary sensor reading, converts it to NDIG BCD digits by sequential
// double-dabble and pushes "<TAG>:<digits>\r\n" one byte at a time into the TX FIFO.
module sensor_ascii_framer #(
    parameter int          DATA_W = 14,
    parameter int          NDIG   = 4,
    parameter logic [7:0]  TAG    = 8'h44
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_tx_full,
    output logic              o_push_tx,
    output logic [7:0]        o_tx_din,
    output logic              o_busy,
    output logic              o_done
);

    localparam int BCD_W = 4 * NDIG;
    localparam int MAXV  = 10 ** NDIG - 1;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int BI_W  = $clog2(NDIG + 4);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [BI_W-1:0]  B_LAST   = BI_W'(NDIG + 3);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] SEND = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] v_q, v_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [BCD_W-1:0]  bcd_adj;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BI_W-1:0]   b_q, b_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] v_clamped;
    logic [7:0]        tx_byte;
    logic              push;

    // Saturate rather than wrap so the BCD register can never overflow.
    always_comb begin
        v_clamped = i_data;
        if (32'(i_data) > 32'(MAXV)) begin
            v_clamped = DATA_W'(MAXV);
        end
    end

    // NOTE: give every always_comb output a default first so no path leaves it unassigned (latch).
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign push = (state_q == SEND) && !i_tx_full;

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    v_d     = v_clamped;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                bcd_d = {bcd_adj[BCD_W-2:0], v_q[DATA_W-1]};
                v_d   = v_q << 1;
                if (cnt_q == CNT_LAST) begin
                    b_d     = '0;
                    state_d = SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SEND: begin
                // Index advances only on an accepted push, so a full FIFO just stalls.
                if (push) begin
                    if (b_q == B_LAST) begin
                        b_d     = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        b_d = b_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_comb begin
        tx_byte = 8'h00;
        if (state_q == SEND) begin
            if (b_q == BI_W'(0)) begin
                tx_byte = TAG;
            end else if (b_q == BI_W'(1)) begin
                tx_byte = 8'h3A;
            end else if (b_q == BI_W'(NDIG + 2)) begin
                tx_byte = 8'h0D;
            end else if (b_q == BI_W'(NDIG + 3)) begin
                tx_byte = 8'h0A;
            end
            for (int i = 0; i < NDIG; i++) begin
                if (b_q == BI_W'(i + 2)) begin
                    tx_byte = {4'h3, bcd_q[4*(NDIG-1-i) +: 4]};
                end
            end
        end
    end

    // NOTE: state uses non-blocking assignments; the data/BCD registers are reset too
    // since they are plain flops, not memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            v_q     <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_push_tx = push;
    assign o_tx_din  = tx_byte;
    assign o_busy    = busy_q;
    assign o_done    = done_q;

endmodule

// File: tb/tb_sensor_ascii_framer.sv
// Directed bench for sensor_ascii_framer: frame contents, timing, stalls, start
// filtering, back-to-back frames and asynchronous abort.
module tb_sensor_ascii_framer;

    typedef logic [7:0] frame_t [8];

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [13:0] i_data;
    logic        i_tx_full;
    logic        o_push_tx;
    logic [7:0]  o_tx_din;
    logic        o_busy;
    logic        o_done;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0] got_q[$];
    int         push_edge_q[$];
    int         done_edge_q[$];

    sensor_ascii_framer #(.DATA_W(14), .NDIG(4), .TAG(8'h44)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_data    (i_data),
        .i_tx_full (i_tx_full),
        .o_push_tx (o_push_tx),
        .o_tx_din  (o_tx_din),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // A push seen at the negedge is accepted by the following rising edge.
    always @(negedge clk) begin
        if (o_push_tx) begin
            got_q.push_back(o_tx_din);
            push_edge_q.push_back(cyc + 1);
        end
        if (o_done) done_edge_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_log();
        got_q.delete();
        push_edge_q.delete();
        done_edge_q.delete();
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns the edge index k at which the start is accepted.
    task automatic start_frame(input logic [13:0] val, output int k);
        @(posedge clk);
        #1;
        i_start = 1'b1;
        i_data  = val;
        k = cyc + 1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int n, input int budget);
        int waited = 0;
        while (done_edge_q.size() < n && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_done_seen"}, 32'(done_edge_q.size() >= n), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input int base, input frame_t f);
        for (int i = 0; i < 8; i++) begin
            if (got_q.size() > base + i) check($sformatf("%s_b%0d", tag, i), 32'(got_q[base+i]), 32'(f[i]));
            else check($sformatf("%s_b%0d_missing", tag, i), 32'd0, 32'd1);
        end
    endtask

    initial begin
        int k;
        int k2;
        frame_t f1234;
        frame_t f0;
        frame_t f9999;
        frame_t f5555;
        frame_t f42;
        f1234 = '{8'h44, 8'h3A, 8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
        f0    = '{8'h44, 8'h3A, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
        f9999 = '{8'h44, 8'h3A, 8'h39, 8'h39, 8'h39, 8'h39, 8'h0D, 8'h0A};
        f5555 = '{8'h44, 8'h3A, 8'h35, 8'h35, 8'h35, 8'h35, 8'h0D, 8'h0A};
        f42   = '{8'h44, 8'h3A, 8'h30, 8'h30, 8'h34, 8'h32, 8'h0D, 8'h0A};

        rst       = 1'b0;
        i_start   = 1'b0;
        i_data    = '0;
        i_tx_full = 1'b0;
        #1;
        check("rst_push", 32'(o_push_tx), 32'd0);
        check("rst_din",  32'(o_tx_din),  32'd0);
        check("rst_busy", 32'(o_busy),    32'd0);
        check("rst_done", 32'(o_done),    32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // 1: nominal frame and its timing
        clear_log();
        start_frame(14'd1234, k);
        check("t1_busy", 32'(o_busy), 32'd1);
        wait_done("t1", 1, 100);
        check("t1_len", 32'(got_q.size()), 32'd8);
        check_frame("t1", 0, f1234);
        if (push_edge_q.size() == 8 && done_edge_q.size() >= 1) begin
            check("t1_first_lat",  32'(push_edge_q[0] - k), 32'd15);
            check("t1_consec",     32'(push_edge_q[7] - push_edge_q[0]), 32'd7);
            check("t1_done_after", 32'(done_edge_q[0]), 32'(push_edge_q[7]));
        end else begin
            check("t1_timing_log", 32'(push_edge_q.size()), 32'd8);
        end
        check("t1_idle_busy", 32'(o_busy), 32'd0);

        // 2: zero and saturated readings
        clear_log();
        start_frame(14'd0, k);
        wait_done("t2a", 1, 100);
        check("t2a_len", 32'(got_q.size()), 32'd8);
        check_frame("t2a", 0, f0);
        clear_log();
        start_frame(14'd16383, k);
        wait_done("t2b", 1, 100);
        check("t2b_len", 32'(got_q.size()), 32'd8);
        check_frame("t2b", 0, f9999);

        // 3: FIFO full for 3 cycles while byte index 3 is pending
        clear_log();
        start_frame(14'd1234, k);
        wait_cyc(k + 17);
        i_tx_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t3_stall%0d", i), 32'(o_push_tx), 32'd0);
            @(posedge clk);
            #1;
        end
        i_tx_full = 1'b0;
        wait_done("t3", 1, 100);
        check("t3_len", 32'(got_q.size()), 32'd8);
        check_frame("t3", 0, f1234);
        if (done_edge_q.size() >= 1) check("t3_lat", 32'(done_edge_q[0] - k), 32'd25);

        // 4: starts during CONV/SEND ignored; start in done cycle chains a frame
        clear_log();
        start_frame(14'd1234, k);
        wait_cyc(k + 5);
        i_start = 1'b1; i_data = 14'd5555;
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_cyc(k + 18);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_cyc(k + 22);
        check("t4_done_pulse", 32'(o_done), 32'd1);
        i_start = 1'b1; i_data = 14'd5555;
        k2 = cyc + 1;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("t4_rebusy", 32'(o_busy), 32'd1);
        wait_done("t4", 2, 100);
        check("t4_len", 32'(got_q.size()), 32'd16);
        check_frame("t4a", 0, f1234);
        check_frame("t4b", 8, f5555);
        if (push_edge_q.size() == 16) check("t4_second_lat", 32'(push_edge_q[8] - k2), 32'd15);

        // 5: asynchronous reset mid-SEND at byte index 4
        clear_log();
        start_frame(14'd1234, k);
        wait_cyc(k + 18);
        rst = 1'b0;
        #1;
        check("t5_push", 32'(o_push_tx), 32'd0);
        check("t5_din",  32'(o_tx_din),  32'd0);
        check("t5_busy", 32'(o_busy),    32'd0);
        check("t5_done", 32'(o_done),    32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("t5_partial_len", 32'(got_q.size()), 32'd4);
        check("t5_no_done", 32'(done_edge_q.size()), 32'd0);
        clear_log();
        start_frame(14'd42, k);
        wait_done("t5", 1, 100);
        check("t5_len", 32'(got_q.size()), 32'd8);
        check_frame("t5", 0, f42);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
